// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by the fetch stage: FETCH_HOLD_BUF_EN.
package riscv_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [XLEN-1:0] instr_t;

  // ADD x0,x0,x0: harmless filler presented whenever nothing valid is fetched.
  localparam instr_t NOP_INSTR        = 32'h0000_0033;
  localparam pc_t    RESET_PC_DEFAULT = 32'h0000_0004;

endpackage

// File: rtl/fetch_hold_buf.sv
// Stall hold buffer for the fetch stage: captures the presented ROM word on the
// first stall cycle so the ROM does not have to re-read the stalled address.
// Compiled only when FETCH_HOLD_BUF_EN is defined.
`ifdef FETCH_HOLD_BUF_EN
module fetch_hold_buf
  import riscv_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic        valid,
  input  logic [31:0] imem_word,
  output logic [31:0] instr
);

  logic [31:0] hold_q;
  logic        hold_vld_q;

  // Capture on the first stalled edge, release when decode accepts or a redirect squashes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: hold_q is data qualified by hold_vld_q; it is reset only so the
      // register never powers up as X, not because its value matters.
      hold_q     <= NOP_INSTR;
      hold_vld_q <= 1'b0;
    end else if (!stall_i || redirect_i) begin
      hold_vld_q <= 1'b0;
    end else if (!hold_vld_q) begin
      hold_q     <= imem_word;
      hold_vld_q <= 1'b1;
    end
  end

  // Present the held word while stalled, otherwise the live ROM word.
  always_comb begin
    instr = NOP_INSTR;
    if (valid) instr = hold_vld_q ? hold_q : imem_word;
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding a synchronous (1-clock) instruction ROM.
// Owns the PC, handles decode stall and branch/jump redirect.
// FETCH_HOLD_BUF_EN: when defined, stalls are served from a hold register
// instead of re-reading the ROM at the stalled address.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = riscv_fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_word,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_valid
);

  import riscv_fetch_pkg::*;

  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] pc_q;      // next PC to fetch
  logic [XLEN-1:0] req_pc_q;  // PC whose word the ROM is returning now
  logic            req_vld_q;

  // PC and in-flight request registers; redirect beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      req_vld_q <= 1'b0;
    end else if (redirect_i) begin
      // NOTE: non-blocking assignments make every register here update from
      // the pre-edge values, so pc_q and req_pc_q shift like a true pipeline.
      req_pc_q  <= redirect_pc;
      req_vld_q <= 1'b1;
      pc_q      <= redirect_pc + STEP;
    end else if (!stall_i) begin
      req_pc_q  <= pc_q;
      req_vld_q <= 1'b1;
      pc_q      <= pc_q + STEP;
    end
  end

  // The wrong-path word arriving in a redirect cycle is squashed combinationally.
  always_comb begin
    if_valid = req_vld_q & ~redirect_i;
    if_pc    = req_pc_q;
  end

`ifdef FETCH_HOLD_BUF_EN
  // ROM keeps fetching pc_q on stall; the hold buffer keeps the presented word.
  always_comb begin
    imem_addr = redirect_i ? redirect_pc : pc_q;
  end

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .redirect_i (redirect_i),
    .valid      (if_valid),
    .imem_word  (imem_word),
    .instr      (if_instr)
  );
`else
  // On stall the ROM re-reads the presented PC so its word stays stable.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives the
    // output, so no latch is inferred.
    imem_addr = pc_q;
    if (redirect_i)   imem_addr = redirect_pc;
    else if (stall_i) imem_addr = req_pc_q;
  end

  // Present the ROM word only when it is on the correct path.
  always_comb begin
    if_instr = if_valid ? imem_word : XLEN'(NOP_INSTR);
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a 1-clock synchronous ROM model.
// Expected presentations are queued per scenario and popped each cycle.
// Works with or without FETCH_HOLD_BUF_EN defined.
module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0033;
  localparam logic [31:0] RST_PC   = 32'h0000_0004;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_word;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_word   (imem_word),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-dependent contents for every ROM slot.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  // Synchronous ROM: word for the address sampled at the previous rising edge.
  always @(posedge clk) imem_word <= rom_word(imem_addr);

  task automatic push(input logic [31:0] pc, input logic vld);
    exp_t e;
    e.pc  = pc;
    e.vld = vld;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: drive inputs, sample this cycle's outputs, pop
  // and compare, then advance to the next falling edge.
  task automatic tick(input logic stall, input logic redir, input logic [31:0] rpc,
                      input string tag);
    exp_t        e;
    logic [31:0] exp_instr;
    stall_i     = stall;
    redirect_i  = redir;
    redirect_pc = rpc;
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, no expected value queued", tag);
    end else begin
      e = exp_q.pop_front();
      exp_instr = e.vld ? rom_word(e.pc) : NOP;
      if (if_valid !== e.vld) begin
        miscompares++;
        $display("FAIL %s if_valid: got %b want %b (pc %h)", tag, if_valid, e.vld, e.pc);
      end
      vectors++;
      if (if_pc !== e.pc) begin
        miscompares++;
        $display("FAIL %s if_pc: got %h want %h", tag, if_pc, e.pc);
      end
      vectors++;
      if (if_instr !== exp_instr) begin
        miscompares++;
        $display("FAIL %s if_instr: got %h want %h (pc %h)", tag, if_instr, exp_instr, e.pc);
      end
      vectors++;
      if (redir) begin
        if (imem_addr !== rpc) begin
          miscompares++;
          $display("FAIL %s imem_addr redirect: got %h want %h", tag, imem_addr, rpc);
        end
      end else if (stall) begin
`ifdef FETCH_HOLD_BUF_EN
        if (e.vld && imem_addr === e.pc) begin
          miscompares++;
          $display("FAIL %s imem_addr stall re-read: got %h want not %h", tag, imem_addr, e.pc);
        end
`else
        if (imem_addr !== e.pc) begin
          miscompares++;
          $display("FAIL %s imem_addr stall: got %h want %h", tag, imem_addr, e.pc);
        end
`endif
      end else begin
        if (imem_addr !== (e.vld ? e.pc + 32'd4 : e.pc)) begin
          miscompares++;
          $display("FAIL %s imem_addr: got %h want %h", tag, imem_addr,
                   e.vld ? e.pc + 32'd4 : e.pc);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s if_valid: got %b want 0", tag, if_valid);
    end
    vectors++;
    if (if_instr !== NOP) begin
      miscompares++;
      $display("FAIL %s if_instr: got %h want %h", tag, if_instr, NOP);
    end
    vectors++;
    if (if_pc !== RST_PC) begin
      miscompares++;
      $display("FAIL %s if_pc: got %h want %h", tag, if_pc, RST_PC);
    end
    vectors++;
    if (imem_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL %s imem_addr: got %h want %h", tag, imem_addr, RST_PC);
    end
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    stall_i     = 1'b0;
    redirect_i  = 1'b0;
    redirect_pc = 32'h0;
    rst_n       = 1'b0;
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    push(RST_PC, 1'b0);
    push(32'd4, 1'b1); push(32'd8, 1'b1); push(32'd12, 1'b1); push(32'd16, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0, "reset_seq");
  endtask

  task automatic test_stall();
    logic [4:0] stall_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    push(RST_PC, 1'b0); push(32'd4, 1'b1);
    for (int i = 0; i < 4; i++) push(32'd8, 1'b1);
    push(32'd12, 1'b1); push(32'd16, 1'b1);
    for (int i = 0; i < 8; i++) tick(stall_v[i][0], 1'b0, 32'h0, "stall3");
  endtask

  task automatic test_redirect();
    do_reset();
    push(RST_PC, 1'b0); push(32'd4, 1'b1); push(32'd8, 1'b1);
    push(32'd12, 1'b0);
    push(32'h40, 1'b1); push(32'h44, 1'b1);
    tick(1'b0, 1'b0, 32'h0, "redir");
    tick(1'b0, 1'b0, 32'h0, "redir");
    tick(1'b0, 1'b0, 32'h0, "redir");
    tick(1'b0, 1'b1, 32'h40, "redir_squash");
    tick(1'b0, 1'b0, 32'h0, "redir_target");
    tick(1'b0, 1'b0, 32'h0, "redir_target");
  endtask

  task automatic test_redirect_over_stall();
    do_reset();
    push(RST_PC, 1'b0); push(32'd4, 1'b1);
    push(32'd8, 1'b0);
    push(32'h100, 1'b1); push(32'h104, 1'b1);
    tick(1'b0, 1'b0, 32'h0, "redir_stall");
    tick(1'b0, 1'b0, 32'h0, "redir_stall");
    tick(1'b1, 1'b1, 32'h100, "redir_stall_both");
    tick(1'b0, 1'b0, 32'h0, "redir_stall_target");
    tick(1'b0, 1'b0, 32'h0, "redir_stall_target");
  endtask

  task automatic test_pc_wrap();
    do_reset();
    push(RST_PC, 1'b0);
    push(32'd4, 1'b0);
    push(32'hFFFF_FFFC, 1'b1); push(32'h0000_0000, 1'b1); push(32'h0000_0004, 1'b1);
    tick(1'b0, 1'b0, 32'h0, "wrap");
    tick(1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_redir");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, "wrap_seq");
  endtask

  task automatic test_stall_after_reset();
    do_reset();
    push(RST_PC, 1'b0); push(RST_PC, 1'b0); push(RST_PC, 1'b0);
    push(32'd4, 1'b1); push(32'd8, 1'b1);
    tick(1'b1, 1'b0, 32'h0, "first_stall");
    tick(1'b1, 1'b0, 32'h0, "first_stall");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, "first_stall_rel");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    push(RST_PC, 1'b0); push(32'd4, 1'b1); push(32'd8, 1'b1); push(32'd8, 1'b1);
    tick(1'b0, 1'b0, 32'h0, "mid_stall");
    tick(1'b0, 1'b0, 32'h0, "mid_stall");
    tick(1'b1, 1'b0, 32'h0, "mid_stall");
    tick(1'b1, 1'b0, 32'h0, "mid_stall");
    // Stall still high; assert reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_stall");
    @(negedge clk);
    stall_i = 1'b0;
    rst_n   = 1'b1;
    exp_q.delete();
    push(RST_PC, 1'b0); push(32'd4, 1'b1);
    tick(1'b0, 1'b0, 32'h0, "after_mid_reset");
    tick(1'b0, 1'b0, 32'h0, "after_mid_reset");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    stall_i     = 1'b0;
    redirect_i  = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_over_stall();
    test_pc_wrap();
    test_stall_after_reset();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
